// File: rtl/game_fsm_if.sv
// Game-control bundle: per-cycle control pulses and scores into the state
// controller, state/lives/timer status back out to display, sound and score logic.
interface game_fsm_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 5
);
    logic                           tick_1ms;
    logic                           start;
    logic                           pause;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores;
    logic [NUM_PLAYERS-1:0]         life_lost;
    logic [2:0]                     game_state;
    logic [1:0]                     winner;
    logic [NUM_PLAYERS*3-1:0]       lives;
    logic                           round_clear;
    logic [15:0]                    time_left;

    modport master (
        output tick_1ms, start, pause, scores, life_lost,
        input  game_state, winner, lives, round_clear, time_left
    );

    modport slave (
        input  tick_1ms, start, pause, scores, life_lost,
        output game_state, winner, lives, round_clear, time_left
    );
endinterface

// File: rtl/game_fsm.sv
// Top-level game state controller: idle, countdown, play, pause and result
// sequencing with per-player lives and win/loss decisions.
module game_fsm #(
    parameter int NUM_PLAYERS    = 2,
    parameter int SCORE_W        = 5,
    parameter int WIN_SCORE      = 9,
    parameter int MAX_LIVES      = 3,
    parameter int COUNTDOWN_MS   = 3000,
    parameter int RESULT_HOLD_MS = 5000
) (
    input  logic      clk,
    input  logic      reset,
    game_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_WON       = 3'd4,
        ST_LOST      = 3'd5
    } state_t;

    localparam int unsigned            WIN_U      = 32'(WIN_SCORE);
    localparam logic [2:0]             LIVES_FULL = 3'(MAX_LIVES);
    localparam logic [15:0]            CD_LOAD    = 16'(COUNTDOWN_MS);
    localparam logic [15:0]            HOLD_LOAD  = 16'(RESULT_HOLD_MS);
    localparam logic [NUM_PLAYERS*3-1:0] LIVES_INIT = {NUM_PLAYERS{LIVES_FULL}};

    state_t                   state_r, state_nx_s;
    logic [NUM_PLAYERS*3-1:0] lives_r, lives_nx_s, lives_dec_s;
    logic [1:0]               winner_r, winner_nx_s;
    logic [15:0]              time_left_r, time_nx_s;
    logic                     round_clear_r, clear_nx_s;
    logic                     win_any_s;
    logic [1:0]               win_idx_s;
    logic                     all_dead_s;

    // Win detection: descending scan so the lowest qualifying index wins.
    always_comb begin
        win_any_s = 1'b0;
        win_idx_s = 2'd0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if ((32'(bus.scores[i*SCORE_W +: SCORE_W]) >= WIN_U) &&
                (lives_r[i*3 +: 3] != 3'd0)) begin
                win_any_s = 1'b1;
                win_idx_s = 2'(i);
            end else begin
                win_any_s = win_any_s;
            end
        end
    end

    // Saturating life decrements and the all-players-out condition after them.
    always_comb begin
        lives_dec_s = lives_r;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bus.life_lost[i] && (lives_r[i*3 +: 3] != 3'd0)) begin
                lives_dec_s[i*3 +: 3] = lives_r[i*3 +: 3] - 3'd1;
            end else begin
                lives_dec_s[i*3 +: 3] = lives_r[i*3 +: 3];
            end
        end
        all_dead_s = (lives_dec_s == '0);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx_s  = state_r;
        lives_nx_s  = lives_r;
        winner_nx_s = winner_r;
        time_nx_s   = time_left_r;
        clear_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx_s  = ST_COUNTDOWN;
                    lives_nx_s  = LIVES_INIT;
                    winner_nx_s = 2'd0;
                    time_nx_s   = CD_LOAD;
                    clear_nx_s  = 1'b1;
                end else begin
                    time_nx_s = 16'd0;
                end
            end
            ST_COUNTDOWN: begin
                if (bus.tick_1ms) begin
                    if (time_left_r <= 16'd1) begin
                        state_nx_s = ST_PLAYING;
                        time_nx_s  = 16'd0;
                    end else begin
                        time_nx_s = time_left_r - 16'd1;
                    end
                end else begin
                    time_nx_s = time_left_r;
                end
            end
            ST_PLAYING: begin
                time_nx_s = 16'd0;
                if (win_any_s) begin
                    // A win freezes lives: same-cycle life_lost pulses are dropped.
                    state_nx_s  = ST_WON;
                    winner_nx_s = win_idx_s;
                    time_nx_s   = HOLD_LOAD;
                end else begin
                    lives_nx_s = lives_dec_s;
                    if (all_dead_s) begin
                        state_nx_s = ST_LOST;
                        time_nx_s  = HOLD_LOAD;
                    end else if (bus.pause) begin
                        state_nx_s = ST_PAUSED;
                    end else begin
                        state_nx_s = ST_PLAYING;
                    end
                end
            end
            ST_PAUSED: begin
                if (bus.pause) begin
                    state_nx_s = ST_PLAYING;
                end else begin
                    state_nx_s = ST_PAUSED;
                end
            end
            ST_WON, ST_LOST: begin
                if (bus.tick_1ms) begin
                    if (time_left_r <= 16'd1) begin
                        state_nx_s = ST_IDLE;
                        time_nx_s  = 16'd0;
                    end else begin
                        time_nx_s = time_left_r - 16'd1;
                    end
                end else begin
                    time_nx_s = time_left_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                time_nx_s  = 16'd0;
            end
        endcase
    end

    // Registered state and outputs; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            lives_r       <= LIVES_INIT;
            winner_r      <= 2'd0;
            time_left_r   <= 16'd0;
            round_clear_r <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            lives_r       <= lives_nx_s;
            winner_r      <= winner_nx_s;
            time_left_r   <= time_nx_s;
            round_clear_r <= clear_nx_s;
        end
    end

    assign bus.game_state  = state_r;
    assign bus.lives       = lives_r;
    assign bus.winner      = winner_r;
    assign bus.time_left   = time_left_r;
    assign bus.round_clear = round_clear_r;
endmodule

// File: doc/game_fsm.md
# game_fsm

Parametrised top-level game state controller for the multi-player game. It sequences the game through idle, countdown, play, pause and result states. It tracks per-player lives and decides win/loss from the score counters. Display, sound and score logic consume its state and strobes to change behaviour.

## Interface

Parameters:

- NUM_PLAYERS, 2: number of players (1..4)
- SCORE_W, 5: width of each player's score field
- WIN_SCORE, 9: score at or above which a player wins
- MAX_LIVES, 3: lives loaded per player at round start (1..7)
- COUNTDOWN_MS, 3000: pre-play countdown length in tick_1ms pulses (>=1)
- RESULT_HOLD_MS, 5000: WON/LOST display hold in tick_1ms pulses (>=1)

Ports:

- clk, in, 1: system clock.
- reset, in, 1: reset, synchronous, active-low.
- tick_1ms, in, 1: single-cycle 1 ms enable, synchronous to clk.
- start, in, 1: single-cycle start pulse.
- pause, in, 1: single-cycle pause-toggle pulse.
- scores, in, NUM_PLAYERS*SCORE_W: packed player scores; player i occupies bits [i*SCORE_W +: SCORE_W].
- life_lost, in, NUM_PLAYERS: per-player single-cycle life-loss pulse.
- game_state, out, 3: current state encoding.
- winner, out, 2: index of the winning player; valid in WON.
- lives, out, NUM_PLAYERS*3: packed remaining lives, 3 bits per player.
- round_clear, out, 1: one-cycle strobe telling the score logic to zero its scores.
- time_left, out, 16: remaining ticks of the current countdown or hold; 0 otherwise.

## Operation

State encodings:

- IDLE = 0, COUNTDOWN = 1, PLAYING = 2, PAUSED = 3, WON = 4, LOST = 5.
- Values 6 and 7 are illegal and go to IDLE on the next clock.

Transitions:

- **IDLE**
  - On start: go to COUNTDOWN.
  - On the same edge, load all lives to MAX_LIVES, load time_left = COUNTDOWN_MS and pulse round_clear for one cycle.
- **COUNTDOWN**
  - Each tick_1ms decrements time_left.
  - The tick that takes time_left from 1 to 0 moves the FSM to PLAYING.
  - start, pause, scores and life_lost are ignored.
- **PLAYING**, evaluated in priority order each cycle:
  1. Win: any player has score >= WIN_SCORE (unsigned compare) and lives > 0. Go to WON; winner = lowest such index.
  2. Life loss: for each player with life_lost set and lives > 0, decrement that player's lives. Lives saturate at 0; a pulse for a player already at 0 is ignored.
  3. Loss: if every player's lives would be 0 after this cycle's decrements, go to LOST.
  4. Pause: on a pause pulse, go to PAUSED.
  - A win detected in the same cycle as life_lost pulses suppresses those decrements; lives are frozen.
  - start is ignored in PLAYING.
- **PAUSED**
  - A pause pulse returns the FSM to PLAYING.
  - scores, life_lost, start and tick_1ms are all ignored.
- **WON / LOST**
  - Load time_left = RESULT_HOLD_MS on entry.
  - Decrement on each tick_1ms; the 1 to 0 tick returns the FSM to IDLE.
  - start is ignored during the hold.
  - lives and winner keep their values until the next round start.
- **Single player (NUM_PLAYERS = 1):** same rules; LOST occurs when player 0 reaches 0 lives.

## Timing

- All outputs are registered.
- An input sampled at edge N is reflected on the outputs after edge N; latency is 1 clock.
- A win or loss condition causes a state change at the first clk edge where it is true; no tick_1ms is required.
- Countdown lasts exactly COUNTDOWN_MS tick_1ms pulses. The hold lasts exactly RESULT_HOLD_MS pulses.
- tick_1ms coinciding with the entry edge is not counted.
- round_clear is high for exactly one cycle, the cycle after the start edge.
- Reset (reset = 0 at a clk edge), including mid-game, forces:
  - game_state = IDLE, winner = 0, round_clear = 0, time_left = 0;
  - every lives field = MAX_LIVES.
- Reset overrides all other inputs on that edge.

## Test plan

Parameters: NUM_PLAYERS = 2, WIN_SCORE = 9, MAX_LIVES = 3, COUNTDOWN_MS = 3, RESULT_HOLD_MS = 4.

1. Reset then start → round_clear high 1 cycle; game_state = 1 and time_left = 3; after 3 ticks, game_state = 2.
2. In PLAYING, set scores player 1 = 9 → next cycle game_state = 4 and winner = 1. After 4 ticks → game_state = 0.
3. In PLAYING:
   - pulse life_lost = 2'b11 three times → after the third pulse, game_state = 5 and lives = {0,0};
   - a further life_lost pulse → lives stay 0.
4. In PLAYING:
   - pulse pause → game_state = 3; score 9 and life_lost pulses during PAUSED are ignored;
   - pulse pause again → game_state = 2, then WON on the next cycle because score 9 is still present.
5. Same cycle: player 0 score = 9 and life_lost = 2'b01 with lives = {1,1} → game_state = 4, winner = 0, lives unchanged at {1,1}.
6. Mid-COUNTDOWN, and separately mid-WON hold: drop reset for 1 cycle → game_state = 0, time_left = 0, lives = {3,3}; start then begins a fresh round.
